// File: rtl/ahb_sram_slave.sv
// AHB-Lite subordinate fronting a word-organised SRAM.
// Supports programmable wait states, byte/half/word writes and a two-cycle ERROR response.
module ahb_sram_slave #(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          DEPTH_WORDS = 1024,
  parameter int          WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        hsel,
  input  logic [31:0] haddr,
  input  logic        hwrite,
  input  logic [1:0]  htrans,
  input  logic [2:0]  hsize,
  input  logic [31:0] hwdata,
  input  logic        hreadyin,
  output logic [31:0] hrdata,
  output logic        hreadyout,
  output logic        hresp
);

  localparam int          AW      = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [31:0] DEPTH_L = 32'(DEPTH_WORDS);
  localparam logic [3:0]  WS_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  typedef enum logic [2:0] {IDLE, WAIT, LAST, ERR1, ERR2} state_t;

  state_t      state;
  logic [3:0]  cnt;
  logic        hready_q;
  logic        hresp_q;

  logic [AW-1:0] idx_p1;
  logic [1:0]    lane_p1;
  logic [2:0]    size_p1;
  logic          wr_p1;
  logic          err_p1;

  logic [31:0] mem [DEPTH_WORDS];

  logic [31:0] offset;
  logic        accept;
  logic        open_slot;
  logic        acc_err;
  logic [3:0]  be;

  // Offsets below BASE_ADDR wrap to huge values and fail the range test.
  function automatic logic access_err(input logic [31:0] off, input logic [2:0] sz);
    logic bad_range;
    logic bad_size;
    logic bad_align;
    bad_range = ({2'b00, off[31:2]} >= DEPTH_L);
    bad_size  = (sz > 3'b010);
    bad_align = ((sz == 3'b001) && off[0]) || ((sz == 3'b010) && (off[1:0] != 2'b00));
    return bad_range || bad_size || bad_align;
  endfunction

  function automatic logic [3:0] lane_en(input logic [2:0] sz, input logic [1:0] ln);
    logic [3:0] en;
    case (sz)
      3'b000:  en = 4'b0001 << ln;
      3'b001:  en = ln[1] ? 4'b1100 : 4'b0011;
      default: en = 4'b1111;
    endcase
    return en;
  endfunction

  assign offset    = haddr - BASE_ADDR;
  assign accept    = hsel && hreadyin && ((htrans == 2'b10) || (htrans == 2'b11));
  assign open_slot = (state == IDLE) || (state == LAST) || (state == ERR2);
  assign acc_err   = access_err(offset, hsize);
  assign be        = lane_en(size_p1, lane_p1);

  // Address phase -> data phase: capture transfer attributes and sequence the response.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      cnt      <= 4'd0;
      hready_q <= 1'b1;
      hresp_q  <= 1'b0;
      idx_p1   <= '0;
      lane_p1  <= 2'b00;
      size_p1  <= 3'b000;
      wr_p1    <= 1'b0;
      err_p1   <= 1'b0;
    end else begin
      case (state)
        WAIT: begin
          if (cnt == 4'd0) begin
            state    <= LAST;
            hready_q <= 1'b1;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        ERR1: begin
          state    <= ERR2;
          hready_q <= 1'b1;
          hresp_q  <= 1'b1;
        end
        default: begin
          if (open_slot && accept) begin
            idx_p1  <= offset[AW+1:2];
            lane_p1 <= offset[1:0];
            size_p1 <= hsize;
            wr_p1   <= hwrite;
            err_p1  <= acc_err;
            if (acc_err) begin
              state    <= ERR1;
              hready_q <= 1'b0;
              hresp_q  <= 1'b1;
            end else if (WAIT_STATES > 0) begin
              state    <= WAIT;
              cnt      <= WS_INIT;
              hready_q <= 1'b0;
              hresp_q  <= 1'b0;
            end else begin
              state    <= LAST;
              hready_q <= 1'b1;
              hresp_q  <= 1'b0;
            end
          end else begin
            state    <= IDLE;
            hready_q <= 1'b1;
            hresp_q  <= 1'b0;
          end
        end
      endcase
    end
  end

  // Data phase: the write commits on the edge that ends LAST, so a following read sees it.
  always_ff @(posedge clk) begin
    if ((state == LAST) && wr_p1 && !err_p1) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[idx_p1][8*i +: 8] <= hwdata[8*i +: 8];
      end
    end
  end

  assign hrdata    = ((state == LAST) && !wr_p1) ? mem[idx_p1] : 32'h0;
  assign hreadyout = hready_q;
  assign hresp     = hresp_q;

endmodule

// File: doc/ahb_sram_slave.md
Name: ahb_sram_slave

Overview:
- AHB-Lite responder (subordinate) end of the bus fabric: one selectable device behind the bus controller's address decoder and read-data mux.
- Provides word-organised SRAM with programmable wait states, byte/halfword/word writes, and a two-cycle ERROR response for illegal accesses.
- Drives hrdata/hreadyout/hresp into the controller's per-device mux slot.
- Pipelined AHB: the address phase of transfer N+1 overlaps the data phase of transfer N.

Parameters:
- BASE_ADDR, 32'h0000_0000, byte address of word 0; must be 4-byte aligned.
- DEPTH_WORDS, 1024, number of 32-bit words; power of two, >= 2.
- WAIT_STATES, 1, hreadyout-low cycles inserted per OKAY data phase; 0 to 15.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- hsel  input  1  device select from the controller decoder.
- haddr  input  32  address-phase byte address.
- hwrite  input  1  1 = write, 0 = read.
- htrans  input  2  IDLE=00, BUSY=01, NONSEQ=10, SEQ=11.
- hsize  input  3  000 = byte, 001 = half, 010 = word; anything else is illegal.
- hwdata  input  32  write data, valid throughout the data phase.
- hreadyin  input  1  bus-wide HREADY (muxed hreadyout of the current data-phase owner).
- hrdata  output  32  read data.
- hreadyout  output  1  0 = extend the data phase.
- hresp  output  1  0 = OKAY, 1 = ERROR.

Behaviour:
- Reset (async, rst low): state IDLE, hreadyout=1, hresp=0, hrdata=0, wait counter=0, all captured address-phase registers cleared. SRAM contents are not cleared.
- Reset asserted mid-transfer aborts the transfer; a pending write is discarded.

Address-phase acceptance:
- A transfer is accepted on a rising edge when hsel && hreadyin && htrans[1].
- IDLE/BUSY transfers, or hsel=0, give a zero-wait OKAY. The following cycle has hreadyout=1, hresp=0, and no memory access.
- On acceptance, capture: word index = (haddr-BASE_ADDR)>>2, byte lane haddr[1:0], hsize, hwrite, and an error flag.

Error conditions (flag set on any of):
- (haddr-BASE_ADDR) >= DEPTH_WORDS*4, including haddr < BASE_ADDR via unsigned wrap.
- hsize > 010.
- hsize=001 with haddr[0]=1.
- hsize=010 with haddr[1:0]!=00.

State machine states: IDLE, WAIT, LAST, ERR1, ERR2.
- IDLE: hreadyout=1, hresp=0. On acceptance:
  - error flag set -> ERR1;
  - else WAIT_STATES>0 -> WAIT, counter=WAIT_STATES-1;
  - else -> LAST.
- WAIT: hreadyout=0, hresp=0. Counter decrements each cycle; at 0 -> LAST. No acceptance is possible because hreadyin is low.
- LAST: hreadyout=1, hresp=0; final data-phase cycle.
  - Write: on this edge, write the enabled lanes of hwdata into mem[index].
  - Read: hrdata = mem[index] combinationally during LAST; hrdata=0 in all other states.
  - Simultaneous acceptance of the next transfer is allowed; next state is chosen as from IDLE. No new transfer -> IDLE.
- ERR1: hreadyout=0, hresp=1 -> ERR2 unconditionally.
- ERR2: hreadyout=1, hresp=1. Acceptance is allowed as from IDLE, otherwise -> IDLE.
- An errored transfer never writes memory; hrdata=0 during error cycles.

Write lane enables (little-endian):
- byte: lane haddr[1:0] only.
- half: lanes {haddr[1],0} and {haddr[1],1}.
- word: all four lanes.
- Disabled lanes keep their old value.

Reads always return the full word; the master extracts the lanes.

Back-to-back write then read of the same word: the write commits on the edge ending the write's LAST cycle. The read's data phase starts on that same edge, so it returns the new data. No forwarding path is needed.

Latency for an OKAY transfer: data phase is WAIT_STATES+1 cycles. Error transfers take exactly 2 cycles regardless of WAIT_STATES.

Test Plan:
- WAIT_STATES=1, BASE_ADDR=0: write word 0xDEADBEEF @0x10, then read @0x10 -> write data phase is 1 low + 1 high hreadyout; read data phase returns hrdata=0xDEADBEEF in its hreadyout=1 cycle, hresp=0 throughout.
- Byte/half writes: word @0x20 holds 0x11223344. Write byte 0xAA @0x21 (hwdata=0x0000AA00), then half 0xBBBB @0x22 (hwdata=0xBBBB0000) -> read @0x20 returns 0xBBBBAA44.
- Errors:
  - word read @0x1002 (misaligned) -> hreadyout 0,1 with hresp 1,1;
  - DEPTH_WORDS=1024, read @0x1000 -> same ERROR pair;
  - write @0x1000 -> same ERROR pair, and mem[0] is unchanged.
- Pipelining: WAIT_STATES=0, back-to-back NONSEQ write 0x5 @0x4 immediately followed by read @0x4 -> hreadyout stays 1, read returns 0x5 the cycle after the write data phase.
- Non-transfers: IDLE and BUSY htrans, and hsel=0 with a NONSEQ write @0x8 -> hreadyout=1, hresp=0, mem[2] unchanged.
- Reset mid-operation: WAIT_STATES=3; a write is in WAIT when rst pulses low -> hreadyout=1, hresp=0, hrdata=0 immediately (async), and the target word is unchanged.
